alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; only 32 is supported.
REQ-002 Parameter SEL_W, default 3: ALU opcode width.
REQ-003 CLOCK  input  1  the only clock; all state updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 REQ_VALID0/REQ_VALID1  input  1 each  the requester has an operation pending.
REQ-006 REQ_READY0/REQ_READY1  output  1 each  the request is accepted this cycle.
REQ-007 REQ_DATA1_n, REQ_DATA2_n (n=0,1)  input  WIDTH each  operands.
REQ-008 REQ_SELECT_n  input  SEL_W; REQ_ROTATE_n  input  1  opcode and shift-mode bit.
REQ-009 ALU_DATA1, ALU_DATA2  output  WIDTH; ALU_SELECT  output  SEL_W; ALU_ROTATE  output  1  registered drive to the shared ALU.
REQ-010 ALU_RESULT  input  WIDTH; ALU_ZERO, ALU_SIGN, ALU_SLTU  input  1 each  ALU outputs and flags.
REQ-011 RSP_VALID0/RSP_VALID1  output  1 each  a response is available for the requester.
REQ-012 RSP_READY0/RSP_READY1  input  1 each  the requester accepts the response.
REQ-013 RSP_RESULT  output  WIDTH; RSP_ZERO, RSP_SIGN, RSP_SLTU  output  1 each  shared response bus, valid only when RSP_VALIDn is high.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; OWNER register (1 bit) identifies the requester served.
REQ-015 Transfer: a request transfers on a cycle with REQ_VALIDn && REQ_READYn; at most one REQ_READYn is high in any cycle.
REQ-016 REQ_READYn is combinational: high only for the arbitration winner, and only in IDLE, or in RESP when the current response is accepted in the same cycle.
REQ-017 Arbitration: round-robin; if both are valid, grant the requester not granted last (LAST pointer); if only one is valid, grant it.
REQ-018 On transfer: latch the winner's operands, SELECT and ROTATE into the ALU_* registers, set OWNER and LAST to the winner, and go to EXEC.
REQ-019 EXEC lasts exactly one cycle: capture ALU_RESULT and the three flags into the RSP_* registers, then go to RESP.
REQ-020 Latency: RSP_VALIDn is high two cycles after the request transfer cycle; throughput is one operation per two cycles with no backpressure.
REQ-021 In RESP: RSP_VALID[OWNER]=1; RSP_RESULT and the flags stay stable until RSP_READY[OWNER].
REQ-022 On response acceptance: go to EXEC if a new transfer occurs in the same cycle, otherwise go to IDLE.
REQ-023 The RSP_READY of the non-owner is ignored; RSP_VALID of the non-owner is 0.
REQ-024 ALU_* registers hold their value outside a transfer cycle, so ALU outputs do not toggle while idle.
REQ-025 The arbiter does not decode SELECT; all 8 opcodes pass through unchanged.

Reset
REQ-026 While RESET=1: state=IDLE; RSP_VALID0/1=0; REQ_READY0/1=0; OWNER=0; LAST=1 (requester 0 wins the first tie); ALU_*, RSP_* registers=0.
REQ-027 RESET asserted in EXEC or RESP discards the operation; no response is issued afterwards.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN. When defined, requester 0 always wins a tie, LAST is unused, and requester 1 may starve. When undefined, the round-robin behaviour of REQ-017 applies.

Structure
REQ-029 Package alu_arb_pkg holds:
- the state enum {IDLE, EXEC, RESP};
- ALU opcode constants: ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SHIFT=5, OR=6, AND=7;
- the WIDTH/SEL_W defaults.
REQ-030 The 2-way grant logic is one sub-module, rr_arbiter2 (inputs: req[1:0], last; output: one-hot gnt[1:0]), and it contains the macro switch.

Verification
REQ-031 Single op: req0 ADD 5,7 at cycle T -> ALU_DATA1=5 in T+1; RSP_VALID0=1, RSP_RESULT=12, RSP_ZERO=0 in T+2.
REQ-032 Tie after reset: both valid (req0 XOR 0xF0,0xFF; req1 SLTU 1,2) with RSP_READY high:
- req0 is served first, RSP_RESULT=0x0F;
- req1 is served next, RSP_RESULT=1, RSP_SLTU=1;
- responses are 2 cycles apart.
REQ-033 Backpressure: RSP_READY0 low for 3 cycles in RESP -> RSP_VALID0 held, RSP_RESULT stable, REQ_READY0/1 both 0; after the release, the pending req1 is granted in the release cycle.
REQ-034 Signed compare: SLT 0xFFFFFFFF,1 -> RSP_RESULT=1; SLT 1,1 -> RSP_RESULT=0, RSP_ZERO=1.
REQ-035 Reset mid-op: RESET in EXEC -> no RSP_VALID for 5 cycles; the next tie is won by req0.
REQ-036 With ALU_ARB_FIXED_PRIO_EN: both valid continuously for 4 ops -> all 4 grants go to req0, and REQ_READY1 never rises.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types, opcodes and default widths for the ALU share arbiter.
package alu_arb_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int SEL_W_DEF = 3;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SLL   = 3'd1;
    localparam logic [2:0] OP_SLT   = 3'd2;
    localparam logic [2:0] OP_SLTU  = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_SHIFT = 3'd5;
    localparam logic [2:0] OP_OR    = 3'd6;
    localparam logic [2:0] OP_AND   = 3'd7;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: 2-way one-hot grant; round-robin on ties, or fixed priority to
// requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
    always_comb gnt = req[0] ? 2'b01 : {req[1], 1'b0};
`else
    // last==1 means requester 1 was served most recently, so requester 0 wins a tie
    always_comb gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
`endif
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external ALU between two valid/ready requesters.
// Tie policy selectable by ALU_ARB_FIXED_PRIO_EN (see rr_arbiter2).
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             REQ_VALID0,
    input  logic             REQ_VALID1,
    output logic             REQ_READY0,
    output logic             REQ_READY1,
    input  logic [WIDTH-1:0] REQ_DATA1_0,
    input  logic [WIDTH-1:0] REQ_DATA2_0,
    input  logic [WIDTH-1:0] REQ_DATA1_1,
    input  logic [WIDTH-1:0] REQ_DATA2_1,
    input  logic [SEL_W-1:0] REQ_SELECT_0,
    input  logic [SEL_W-1:0] REQ_SELECT_1,
    input  logic             REQ_ROTATE_0,
    input  logic             REQ_ROTATE_1,
    output logic [WIDTH-1:0] ALU_DATA1,
    output logic [WIDTH-1:0] ALU_DATA2,
    output logic [SEL_W-1:0] ALU_SELECT,
    output logic             ALU_ROTATE,
    input  logic [WIDTH-1:0] ALU_RESULT,
    input  logic             ALU_ZERO,
    input  logic             ALU_SIGN,
    input  logic             ALU_SLTU,
    output logic             RSP_VALID0,
    output logic             RSP_VALID1,
    input  logic             RSP_READY0,
    input  logic             RSP_READY1,
    output logic [WIDTH-1:0] RSP_RESULT,
    output logic             RSP_ZERO,
    output logic             RSP_SIGN,
    output logic             RSP_SLTU
);
    state_e     state_q, state_d;
    logic       owner_q, last_q;
    logic [1:0] gnt;
    logic       accept, open, xfer, win;

    rr_arbiter2 u_arb (.req({REQ_VALID1, REQ_VALID0}), .last(last_q), .gnt(gnt));

    assign accept     = (state_q == RESP) && (owner_q ? RSP_READY1 : RSP_READY0);
    // a new request can enter only when the ALU slot is empty or frees up this cycle
    assign open       = !RESET && ((state_q == IDLE) || accept);
    assign REQ_READY0 = open & gnt[0];
    assign REQ_READY1 = open & gnt[1];
    assign xfer       = REQ_READY0 | REQ_READY1;
    assign win        = gnt[1];
    assign RSP_VALID0 = !RESET && (state_q == RESP) && !owner_q;
    assign RSP_VALID1 = !RESET && (state_q == RESP) && owner_q;

    always_comb begin
        state_d = IDLE;
        if (xfer) state_d = EXEC;
        else if (state_q == EXEC || (state_q == RESP && !accept)) state_d = RESP;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            ALU_DATA1  <= '0;
            ALU_DATA2  <= '0;
            ALU_SELECT <= '0;
            ALU_ROTATE <= 1'b0;
            RSP_RESULT <= '0;
            RSP_ZERO   <= 1'b0;
            RSP_SIGN   <= 1'b0;
            RSP_SLTU   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                owner_q    <= win;
                last_q     <= win;
                ALU_DATA1  <= win ? REQ_DATA1_1 : REQ_DATA1_0;
                ALU_DATA2  <= win ? REQ_DATA2_1 : REQ_DATA2_0;
                ALU_SELECT <= win ? REQ_SELECT_1 : REQ_SELECT_0;
                ALU_ROTATE <= win ? REQ_ROTATE_1 : REQ_ROTATE_0;
            end
            if (state_q == EXEC) begin
                RSP_RESULT <= ALU_RESULT;
                RSP_ZERO   <= ALU_ZERO;
                RSP_SIGN   <= ALU_SIGN;
                RSP_SLTU   <= ALU_SLTU;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of the ALU share arbiter
// against a transaction-level model; also covers ALU_ARB_FIXED_PRIO_EN builds.
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;
    logic clk, rst;
    logic v0, v1, qr0, qr1, rr0, rr1, av0, av1;
    logic [31:0] a0, b0, a1, b1, ad1, ad2, res, alu_res;
    logic [2:0] s0, s1, as;
    logic r0, r1, ar, z, sg, lt;
    int errors = 0, checks = 0;

    alu_share_arbiter dut (
        .CLOCK(clk), .RESET(rst),
        .REQ_VALID0(v0), .REQ_VALID1(v1), .REQ_READY0(qr0), .REQ_READY1(qr1),
        .REQ_DATA1_0(a0), .REQ_DATA2_0(b0), .REQ_DATA1_1(a1), .REQ_DATA2_1(b1),
        .REQ_SELECT_0(s0), .REQ_SELECT_1(s1), .REQ_ROTATE_0(r0), .REQ_ROTATE_1(r1),
        .ALU_DATA1(ad1), .ALU_DATA2(ad2), .ALU_SELECT(as), .ALU_ROTATE(ar),
        .ALU_RESULT(alu_res), .ALU_ZERO(alu_res == 32'd0), .ALU_SIGN(alu_res[31]), .ALU_SLTU(ad1 < ad2),
        .RSP_VALID0(av0), .RSP_VALID1(av1), .RSP_READY0(rr0), .RSP_READY1(rr1),
        .RSP_RESULT(res), .RSP_ZERO(z), .RSP_SIGN(sg), .RSP_SLTU(lt)
    );

    function automatic logic [31:0] alu_ref(input logic [2:0] sel, input logic rot, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (sel)
            OP_ADD:   return a + b;
            OP_SLL:   return a << sh;
            OP_SLT:   return {31'd0, $signed(a) < $signed(b)};
            OP_SLTU:  return {31'd0, a < b};
            OP_XOR:   return a ^ b;
            OP_SHIFT: return rot ? ((a >> sh) | (a << (32 - sh))) : (a >> sh);
            OP_OR:    return a | b;
            default:  return a & b;
        endcase
    endfunction

    assign alu_res = alu_ref(as, ar, ad1, ad2);

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic clr;
        v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
    endtask

    task automatic do_reset;
        @(negedge clk); rst = 1; clr;
        @(negedge clk);
        @(negedge clk); rst = 0;
    endtask

    task automatic test_reset;
        @(negedge clk); rst = 1; v0 = 1; v1 = 1; a0 = 32'h1234; b0 = 1; s0 = OP_ADD; r0 = 0;
        @(negedge clk); #1;
        checks++; if ({qr1, qr0} !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", {qr1, qr0}); end
        checks++; if ({av1, av0} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", {av1, av0}); end
        checks++; if ({ad1, ad2, as, ar} !== 68'd0) begin errors++; $display("FAIL reset_alu_regs got %h want 0", {ad1, ad2, as, ar}); end
        checks++; if ({res, z, sg, lt} !== 35'd0) begin errors++; $display("FAIL reset_rsp_regs got %h want 0", {res, z, sg, lt}); end
        rst = 0; clr;
    endtask

    task automatic test_single;
        @(negedge clk); v0 = 1; s0 = OP_ADD; r0 = 0; a0 = 5; b0 = 7; #1;
        checks++; if ({qr1, qr0} !== 2'b01) begin errors++; $display("FAIL single_grant got %b want 01", {qr1, qr0}); end
        @(negedge clk); v0 = 0; #1;
        checks++; if (ad1 !== 32'd5 || ad2 !== 32'd7) begin errors++; $display("FAIL single_alu_data got %0d,%0d want 5,7", ad1, ad2); end
        checks++; if (av0 !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", av0); end
        @(negedge clk); #1;
        checks++; if (av0 !== 1'b1 || av1 !== 1'b0) begin errors++; $display("FAIL single_rsp_valid got %b%b want 01", av1, av0); end
        checks++; if (res !== 32'd12 || z !== 1'b0) begin errors++; $display("FAIL single_result got %0d z=%b want 12 z=0", res, z); end
        @(negedge clk); #1;
        checks++; if (av0 !== 1'b0) begin errors++; $display("FAIL single_rsp_drop got %b want 0", av0); end
    endtask

    task automatic test_tie;
        do_reset;
        @(negedge clk);
        v0 = 1; s0 = OP_XOR; r0 = 0; a0 = 32'hF0; b0 = 32'hFF;
        v1 = 1; s1 = OP_SLTU; r1 = 0; a1 = 1; b1 = 2; #1;
        checks++; if ({qr1, qr0} !== 2'b01) begin errors++; $display("FAIL tie_first_grant got %b want 01", {qr1, qr0}); end
        @(negedge clk); v0 = 0;
        @(negedge clk); #1;
        checks++; if (av0 !== 1'b1 || res !== 32'h0F) begin errors++; $display("FAIL tie_rsp0 got v=%b r=%h want v=1 r=0f", av0, res); end
        checks++; if ({qr1, qr0} !== 2'b10) begin errors++; $display("FAIL tie_second_grant got %b want 10", {qr1, qr0}); end
        @(negedge clk); v1 = 0; #1;
        checks++; if ({av1, av0} !== 2'b00) begin errors++; $display("FAIL tie_gap got %b want 00", {av1, av0}); end
        @(negedge clk); #1;
        checks++; if (av1 !== 1'b1 || res !== 32'd1 || lt !== 1'b1) begin errors++; $display("FAIL tie_rsp1 got v=%b r=%h sltu=%b want 1 1 1", av1, res, lt); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        v0 = 1; s0 = OP_OR; r0 = 0; a0 = 3; b0 = 4; rr0 = 0;
        v1 = 1; s1 = OP_ADD; r1 = 0; a1 = 1; b1 = 1; rr1 = 1; #1;
        checks++; if ({qr1, qr0} !== 2'b01) begin errors++; $display("FAIL bp_grant got %b want 01", {qr1, qr0}); end
        @(negedge clk); v0 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (av0 !== 1'b1 || res !== 32'd7) begin errors++; $display("FAIL bp_hold%0d got v=%b r=%0d want 1 7", i, av0, res); end
            checks++; if ({qr1, qr0} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b want 00", i, {qr1, qr0}); end
        end
        @(negedge clk); rr0 = 1; #1;
        checks++; if (qr1 !== 1'b1 || av0 !== 1'b1) begin errors++; $display("FAIL bp_release got rdy1=%b v0=%b want 1 1", qr1, av0); end
        @(negedge clk); v1 = 0;
        @(negedge clk); #1;
        checks++; if (av1 !== 1'b1 || res !== 32'd2) begin errors++; $display("FAIL bp_rsp1 got v=%b r=%0d want 1 2", av1, res); end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); v0 = 1; s0 = sel; r0 = 0; a0 = a; b0 = b; rr0 = 1;
        @(negedge clk); v0 = 0;
        @(negedge clk); #1;
    endtask

    task automatic test_slt;
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        checks++; if (av0 !== 1'b1 || res !== 32'd1) begin errors++; $display("FAIL slt_neg got v=%b r=%0d want 1 1", av0, res); end
        run_op(OP_SLT, 32'd1, 32'd1);
        checks++; if (av0 !== 1'b1 || res !== 32'd0 || z !== 1'b1) begin errors++; $display("FAIL slt_eq got v=%b r=%0d z=%b want 1 0 1", av0, res, z); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk); v0 = 1; s0 = OP_ADD; r0 = 0; a0 = 9; b0 = 9;
        @(negedge clk); v0 = 0; rst = 1;
        @(negedge clk); rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++; if ({av1, av0} !== 2'b00) begin errors++; $display("FAIL midreset_no_rsp%0d got %b want 00", i, {av1, av0}); end
        end
        @(negedge clk); v0 = 1; v1 = 1; #1;
        checks++; if ({qr1, qr0} !== 2'b01) begin errors++; $display("FAIL midreset_tie got %b want 01", {qr1, qr0}); end
        do_reset;
    endtask

    task automatic test_back_to_back;
        int g[$];
        int hi1;
        hi1 = 0;
        do_reset;
        v0 = 1; v1 = 1; s0 = OP_ADD; s1 = OP_XOR; a0 = 1; b0 = 2; a1 = 3; b1 = 4;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (qr0 && qr1) begin errors++; $display("FAIL b2b_onehot%0d got 11 want at most one", i); end
            if (qr0) g.push_back(0);
            if (qr1) begin g.push_back(1); hi1++; end
            @(negedge clk);
        end
        checks++; if (g.size() !== 5) begin errors++; $display("FAIL b2b_count got %0d want 5", g.size()); end
        for (int i = 0; i < 4 && i < g.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            checks++; if (g[i] !== 0) begin errors++; $display("FAIL b2b_grant%0d got %0d want 0", i, g[i]); end
`else
            checks++; if (g[i] !== i % 2) begin errors++; $display("FAIL b2b_grant%0d got %0d want %0d", i, g[i], i % 2); end
`endif
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        checks++; if (hi1 !== 0) begin errors++; $display("FAIL b2b_starve got %0d want 0", hi1); end
`else
        checks++; if (hi1 !== 2) begin errors++; $display("FAIL b2b_req1_grants got %0d want 2", hi1); end
`endif
        do_reset;
    endtask

    task automatic test_random;
        int last_m, w, mask, hold;
        logic [31:0] ea, eb, er;
        logic [2:0] es;
        logic er_rot;
        logic [1:0] oh;
        do_reset;
        last_m = 1;
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            mask = $urandom_range(1, 3);
            a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom; s0 = 3'($urandom); r0 = 1'($urandom);
            a1 = $urandom_range(0, 40); b1 = $urandom; s1 = 3'($urandom); r1 = 1'($urandom);
            v0 = mask[0]; v1 = mask[1]; rr0 = 0; rr1 = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
            w = mask[0] ? 0 : 1;
`else
            w = (mask == 3) ? (last_m == 1 ? 0 : 1) : (mask == 1 ? 0 : 1);
`endif
            oh = (w == 1) ? 2'b10 : 2'b01;
            ea = w ? a1 : a0; eb = w ? b1 : b0; es = w ? s1 : s0; er_rot = w ? r1 : r0;
            er = alu_ref(es, er_rot, ea, eb);
            #1;
            checks++; if ({qr1, qr0} !== oh) begin errors++; $display("FAIL rnd_grant%0d got %b want %b", it, {qr1, qr0}, oh); end
            @(negedge clk); v0 = 0; v1 = 0;
            @(negedge clk); #1;
            checks++; if ({av1, av0} !== oh || res !== er || z !== (er == 0) || sg !== er[31] || lt !== (ea < eb))
                begin errors++; $display("FAIL rnd_rsp%0d got v=%b r=%h f=%b%b%b want v=%b r=%h f=%b%b%b", it, {av1, av0}, res, z, sg, lt, oh, er, er == 0, er[31], ea < eb); end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                if (w == 1) rr0 = 1'($urandom); else rr1 = 1'($urandom);
                @(negedge clk); #1;
                checks++; if ({av1, av0} !== oh || res !== er) begin errors++; $display("FAIL rnd_hold%0d got v=%b r=%h want v=%b r=%h", it, {av1, av0}, res, oh, er); end
            end
            if (w == 1) rr1 = 1; else rr0 = 1;
            @(negedge clk); #1;
            checks++; if ({av1, av0} !== 2'b00 || ad1 !== ea || ad2 !== eb) begin errors++; $display("FAIL rnd_done%0d got v=%b d1=%h d2=%h want 00 %h %h", it, {av1, av0}, ad1, ad2, ea, eb); end
            rr0 = 0; rr1 = 0;
            last_m = w;
        end
    endtask

    initial begin
        rst = 1; clr;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; s0 = 0; s1 = 0; r0 = 0; r1 = 0;
        test_reset;
        test_single;
        test_tie;
        test_backpressure;
        test_slt;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
